// File: rtl/rf_seq_pkg.sv
// Shared definitions for the RF command sequencer: command width, state encoding,
// datapath opcodes and command field helpers.
package rf_seq_pkg;

    localparam int CMD_W = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    localparam logic [2:0] OP_RS1 = 3'd0;
    localparam logic [2:0] OP_RS2 = 3'd1;
    localparam logic [2:0] OP_RD  = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd3;
    localparam logic [2:0] OP_LDI = 3'd4;
    localparam logic [2:0] OP_ADD = 3'd5;
    localparam logic [2:0] OP_AND = 3'd6;
    localparam logic [2:0] OP_OUT = 3'd7;

    function automatic logic [2:0] cmd_opcode(input logic [CMD_W-1:0] cmd);
        return cmd[2:0];
    endfunction

    function automatic logic [4:0] cmd_operand(input logic [CMD_W-1:0] cmd);
        return cmd[7:3];
    endfunction

endpackage

// File: rtl/rf_cmd_sequencer_if.sv
// Valid/ready command channel from the sequencer (master) to the register-file datapath (slave).
interface rf_cmd_sequencer_if;

    logic                          cmd_valid;
    logic [rf_seq_pkg::CMD_W-1:0]  cmd_data;
    logic                          cmd_ready;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);

endinterface

// File: rtl/rf_seq_progbuf.sv
// Program buffer: DEPTH command bytes, synchronous write port, asynchronous read port.
module rf_seq_progbuf
    import rf_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [CMD_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [CMD_W-1:0] rdata
);

    logic [CMD_W-1:0] mem [DEPTH];

    // NOTE: storage is deliberately left out of reset; prog_len alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rf_cmd_sequencer.sv
// Captures a short command program and replays it loops+1 times over a valid/ready channel.
// Optional single-step issue is compiled in with `define RF_SEQ_STEP_EN.
module rf_cmd_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PC_W   = $clog2(DEPTH),
    parameter int LOOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [CMD_W-1:0]   wr_data,
    input  logic               clear,
    input  logic               start,
    input  logic [LOOP_W-1:0]  loops,
    input  logic               abort,
`ifdef RF_SEQ_STEP_EN
    input  logic               step_mode,
    input  logic               step,
`endif
    rf_cmd_sequencer_if.master cmd,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W:0]      prog_len
);

    localparam logic [1:0] IDLE = SEQ_IDLE;
    localparam logic [1:0] RUN  = SEQ_RUN;
    localparam logic [1:0] DONE = SEQ_DONE;

    logic [1:0]        state;
    logic [LOOP_W-1:0] iter;

    logic run_st, fire, last_cmd, full, abort_done, buf_we;

    assign run_st     = (state == RUN);
    assign fire       = cmd.cmd_valid && cmd.cmd_ready;
    assign last_cmd   = ({1'b0, pc} == prog_len - (PC_W+1)'(1));
    assign full       = (prog_len == (PC_W+1)'(DEPTH));
    assign abort_done = (state == DONE) && abort;
    // clear and start both take precedence over a write arriving in the same cycle.
    assign buf_we     = !run_st && !abort_done && wr_en && !clear && !start && !full;

    assign busy = run_st;
    assign done = (state == DONE);

`ifdef RF_SEQ_STEP_EN
    logic armed;

    always_ff @(posedge clk) begin
        if (!rst_n)                               armed <= 1'b0;
        else if (!run_st || !step_mode || abort)  armed <= 1'b0;
        else if (fire)                            armed <= 1'b0;
        else if (step)                            armed <= 1'b1;
    end

    assign cmd.cmd_valid = run_st && (!step_mode || armed);
`else
    assign cmd.cmd_valid = run_st;
`endif

    rf_seq_progbuf #(.DEPTH(DEPTH)) u_progbuf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (prog_len[PC_W-1:0]),
        .wdata (wr_data),
        .raddr (pc),
        .rdata (cmd.cmd_data)
    );

    // NOTE: all sequential state is assigned with <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            iter     <= '0;
            prog_len <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (wr_en || start) err <= 1'b1;
                    if (abort) begin
                        state <= IDLE;
                        pc    <= '0;
                    end else if (fire) begin
                        if (!last_cmd) begin
                            pc <= pc + PC_W'(1);
                        end else if (iter != '0) begin
                            iter <= iter - LOOP_W'(1);
                            pc   <= '0;
                        end else begin
                            state <= DONE;
                            pc    <= '0;
                        end
                    end
                end
                default: begin
                    if (abort_done) begin
                        state <= IDLE;
                    end else if (clear) begin
                        prog_len <= '0;
                    end else if (start) begin
                        if (wr_en) err <= 1'b1;
                        if (prog_len != '0) begin
                            state <= RUN;
                            pc    <= '0;
                            iter  <= loops;
                        end else begin
                            state <= DONE;
                        end
                    end else if (wr_en) begin
                        if (full) err      <= 1'b1;
                        else      prog_len <= prog_len + (PC_W+1)'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// Directed self-checking bench for rf_cmd_sequencer (default build, DEPTH=16).
module tb_rf_cmd_sequencer;
    import rf_seq_pkg::*;

    localparam int DEPTH  = 16;
    localparam int PC_W   = 4;
    localparam int LOOP_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [CMD_W-1:0]  wr_data;
    logic              clear;
    logic              start;
    logic [LOOP_W-1:0] loops;
    logic              abort;
    logic              step_mode;
    logic              step;
    logic              busy, done, err;
    logic [PC_W-1:0]   pc;
    logic [PC_W:0]     prog_len;

    int n_checks = 0;
    int n_err    = 0;

    rf_cmd_sequencer_if cmd_if ();

    rf_cmd_sequencer #(.DEPTH(DEPTH), .PC_W(PC_W), .LOOP_W(LOOP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clear    (clear),
        .start    (start),
        .loops    (loops),
        .abort    (abort),
`ifdef RF_SEQ_STEP_EN
        .step_mode(step_mode),
        .step     (step),
`endif
        .cmd      (cmd_if),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .pc       (pc),
        .prog_len (prog_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_start(input logic [LOOP_W-1:0] n);
        loops = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [7:0] exp_ab [2];
    logic [7:0] prev_data;
    logic       fire;
    int         hs;

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; clear = 1'b0; start = 1'b0;
        loops = '0; abort = 1'b0; step_mode = 1'b0; step = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_prog_len", 32'(prog_len), 32'd0);
        check("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
        rst_n = 1'b1;

        // Three-command program, single pass at full rate.
        write_byte(8'h08);
        write_byte(8'h11);
        write_byte(8'h1A);
        check("t1_prog_len", 32'(prog_len), 32'd3);
        cmd_if.cmd_ready = 1'b1;
        pulse_start(4'd0);
        check("t1_valid0", 32'(cmd_if.cmd_valid), 32'd1);
        check("t1_cmd0", 32'(cmd_if.cmd_data), 32'h08);
        tick();
        check("t1_cmd1", 32'(cmd_if.cmd_data), 32'h11);
        tick();
        check("t1_cmd2", 32'(cmd_if.cmd_data), 32'h1A);
        check("t1_pc2", 32'(pc), 32'd2);
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_valid_off", 32'(cmd_if.cmd_valid), 32'd0);

        // Two commands, loops=2, ready toggling every cycle.
        pulse_clear();
        write_byte(8'h0C);
        write_byte(8'h25);
        exp_ab[0] = 8'h0C;
        exp_ab[1] = 8'h25;
        pulse_start(4'd2);
        hs = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            cmd_if.cmd_ready = (i % 2 == 0);
            prev_data = cmd_if.cmd_data;
            fire = cmd_if.cmd_valid && cmd_if.cmd_ready;
            if (fire) begin
                check($sformatf("t2_hs%0d", hs), 32'(cmd_if.cmd_data), 32'(exp_ab[hs % 2]));
                hs++;
            end
            tick();
            if (!fire && busy) check("t2_stall_stable", 32'(cmd_if.cmd_data), 32'(prev_data));
        end
        check("t2_hs_count", 32'(hs), 32'd6);
        check("t2_done", 32'(done), 32'd1);
        check("t2_err", 32'(err), 32'd0);

        // Overfill: 17 writes into a 16-entry buffer.
        pulse_clear();
        for (int i = 0; i < 17; i++) write_byte(8'h40 + 8'(i));
        check("t3_prog_len", 32'(prog_len), 32'd16);
        check("t3_err", 32'(err), 32'd1);
        cmd_if.cmd_ready = 1'b0;
        pulse_start(4'd0);
        check("t3_buf0", 32'(cmd_if.cmd_data), 32'h40);
        cmd_if.cmd_ready = 1'b1;
        repeat (15) tick();
        check("t3_pc15", 32'(pc), 32'd15);
        check("t3_buf15", 32'(cmd_if.cmd_data), 32'h4F);
        tick();
        check("t3_done", 32'(done), 32'd1);

        // Abort after two handshakes, then a fresh start replays from entry 0.
        pulse_clear();
        write_byte(8'h03);
        write_byte(8'h0B);
        write_byte(8'h13);
        write_byte(8'h1B);
        cmd_if.cmd_ready = 1'b1;
        pulse_start(4'd0);
        tick();
        tick();
        check("t4_pc_before_abort", 32'(pc), 32'd2);
        abort = 1'b1;
        cmd_if.cmd_ready = 1'b0;
        tick();
        abort = 1'b0;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_done", 32'(done), 32'd0);
        check("t4_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("t4_pc", 32'(pc), 32'd0);
        check("t4_prog_len", 32'(prog_len), 32'd4);
        pulse_start(4'd0);
        check("t4_restart_cmd", 32'(cmd_if.cmd_data), 32'h03);
        check("t4_restart_valid", 32'(cmd_if.cmd_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Empty program start, then clear+start together.
        pulse_clear();
        check("t5_valid_at_start", 32'(cmd_if.cmd_valid), 32'd0);
        pulse_start(4'd1);
        check("t5_done", 32'(done), 32'd1);
        check("t5_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_done", 32'(done), 32'd0);
        write_byte(8'h2C);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("t5_cs_busy", 32'(busy), 32'd0);
        check("t5_cs_done", 32'(done), 32'd0);
        check("t5_cs_prog_len", 32'(prog_len), 32'd0);

        // Reset in the middle of a run.
        write_byte(8'h15);
        write_byte(8'h1D);
        cmd_if.cmd_ready = 1'b1;
        pulse_start(4'd3);
        tick();
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_pc_pre", 32'(pc), 32'd1);
        rst_n = 1'b0;
        tick();
        check("t6_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_prog_len", 32'(prog_len), 32'd0);
        check("t6_pc", 32'(pc), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_cmd_sequencer.md
Name: rf_cmd_sequencer

Overview:
Micro-sequencer in front of the 32x32 register-file/ALU datapath. It captures a short program of 8-bit datapath commands into a local buffer, then replays the program N+1 times. Each command is issued over a valid/ready handshake, so the datapath runs at full rate without an external host feeding it every cycle. Command format matches the datapath encoding: bits [2:0] are the opcode, bits [7:3] are the operand.

Parameters:
DEPTH, 16, program buffer entries (power of two, >= 2)
PC_W, $clog2(DEPTH), program counter width
LOOP_W, 4, loop-count width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
wr_en  in  1  append wr_data to program buffer
wr_data  in  8  command byte to append
clear  in  1  empty the program buffer (prog_len <= 0)
start  in  1  begin execution
loops  in  LOOP_W  extra repetitions; sampled at start
abort  in  1  terminate execution
cmd_valid  out  1  command present on cmd_data
cmd_data  out  8  current command byte
cmd_ready  in  1  datapath accepts command
busy  out  1  high in RUN
done  out  1  high in DONE
err  out  1  sticky: a write or start was dropped
pc  out  PC_W  index of current command
prog_len  out  PC_W+1  number of stored commands, 0..DEPTH

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; prog_len, pc, iter, cmd_valid, done, err, busy all 0.
  - Buffer contents are not reset.
- States are IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE); cmd_valid = (state==RUN).
- Writes, in IDLE or DONE:
  - wr_en with prog_len<DEPTH stores buf[prog_len]<=wr_data, then prog_len++.
  - wr_en with prog_len==DEPTH is dropped and sets err.
- clear, in IDLE or DONE: prog_len<=0.
- Priority among clear, start and wr_en in the same cycle:
  - clear beats start and wr_en; start and the write are dropped, err unchanged.
  - start beats wr_en; the write is dropped and err is set.
- start, in IDLE or DONE:
  - prog_len>0: go to RUN, pc<=0, iter<=loops.
  - prog_len==0: go to DONE next cycle; no command issued.
- RUN:
  - cmd_data = buf[pc], read asynchronously.
  - cmd_data and cmd_valid stay stable while cmd_ready is low.
  - On a handshake (cmd_valid && cmd_ready):
    - pc<prog_len-1: pc++.
    - Otherwise, iter>0: iter--, pc<=0.
    - Otherwise: go to DONE, pc<=0.
  - The first command appears the cycle after start; throughput is 1 command/cycle with cmd_ready held high.
  - Total commands issued = prog_len*(loops+1); loops=max gives 2^LOOP_W passes.
- In RUN, wr_en, clear and start are ignored; wr_en and start also set err.
- abort:
  - In RUN: next state IDLE, pc<=0. cmd_valid drops the next cycle. A handshake in the abort cycle still counts as accepted by the datapath. Buffer is retained.
  - In DONE: go to IDLE.
- DONE holds until start (re-run) or abort.
- err clears only on reset.

Optional Feature:
RF_SEQ_STEP_EN
- Adds inputs step_mode (1) and step (1).
- With the macro defined and step_mode=1 in RUN:
  - A step pulse sets an internal armed flag.
  - cmd_valid = armed.
  - A handshake clears armed.
  - Result: one command per step pulse. A step while already armed is dropped.
- With step_mode=0, behaviour is identical to the macro-undefined build.
- Without the macro, the ports and the armed flag are absent and cmd_valid follows the RUN state only.

Decomposition:
- Package rf_seq_pkg holds:
  - state enum (IDLE, RUN, DONE).
  - CMD_W=8.
  - opcode constants: OP_RS1=0, OP_RS2=1, OP_RD=2, OP_SHL=3, OP_LDI=4, OP_ADD=5, OP_AND=6, OP_OUT=7.
  - field extract helpers for opcode [2:0] and operand [7:3].
- Sub-module rf_seq_progbuf: DEPTH x 8 storage, synchronous write, asynchronous read, no reset.

Test Plan:
1. Write 0x08,0x11,0x1A; start with loops=0; cmd_ready=1 -> cmd_data 0x08, 0x11, 0x1A on three consecutive cycles, then done=1, busy=0, err=0.
2. Write A=0x0C, B=0x25; loops=2; cmd_ready alternating 1,0 -> exactly 6 handshakes in order A,B,A,B,A,B; cmd_data stable during stall cycles; then done=1.
3. Write 17 bytes with DEPTH=16 -> prog_len=16, err=1, buf[15] equals the 16th byte.
4. 4-entry program, abort after 2 handshakes -> next cycle state IDLE, cmd_valid=0, prog_len=4; a fresh start replays from buf[0].
5. clear then start -> done=1 the cycle after start, cmd_valid never asserted. Separately, clear and start in the same cycle -> stays IDLE.
6. rst_n low mid-RUN -> after the edge cmd_valid=0, busy=0, done=0, err=0, prog_len=0, pc=0.
